// File: rtl/axis_pkt_marker.sv
// axis_pkt_marker: per-channel AXI-stream packet counter that stamps the count into the stream by mode.
// Define AXIS_PKT_MARKER_TAG_EN to carry the channel index in the top 8 marker bits.
module axis_pkt_marker #(
    parameter int          NUM_CHANNELS = 1,
    parameter int          WIDTH        = 32,
    parameter int          CNT_WIDTH    = 32,
    parameter logic [7:0]  SR_BASE      = 8'd160,
    parameter logic [31:0] FILL_DEFAULT = 32'hABCDBEEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CHANNELS-1:0]         set_stb,
    input  logic [8*NUM_CHANNELS-1:0]       set_addr,
    input  logic [32*NUM_CHANNELS-1:0]      set_data,
    input  logic [WIDTH*NUM_CHANNELS-1:0]   i_tdata,
    input  logic [NUM_CHANNELS-1:0]         i_tlast,
    input  logic [NUM_CHANNELS-1:0]         i_tvalid,
    output logic [NUM_CHANNELS-1:0]         i_tready,
    output logic [WIDTH*NUM_CHANNELS-1:0]   o_tdata,
    output logic [NUM_CHANNELS-1:0]         o_tlast,
    output logic [NUM_CHANNELS-1:0]         o_tvalid,
    input  logic [NUM_CHANNELS-1:0]         o_tready,
    output logic [CNT_WIDTH*NUM_CHANNELS-1:0] pkt_count
);
    typedef enum logic {IDLE, IN_PKT} state_t;
    genvar g;
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        state_t               r_state, w_state;
        logic [1:0]           r_mode, r_pkt_mode, w_mode;
        logic [WIDTH-1:0]     r_fill, w_marker, w_data, r_out_data, r_skid_data;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [7:0]           w_addr;
        logic [31:0]          w_sdata;
        logic                 r_out_valid, r_out_last, r_skid_valid, r_skid_last;
        logic                 w_stb, w_in, w_first, w_mark, w_out_ready;
        assign w_addr      = set_addr[8*g +: 8];
        assign w_sdata     = set_data[32*g +: 32];
        assign w_stb       = set_stb[g];
        assign w_in        = i_tvalid[g] & ~r_skid_valid;
        assign w_first     = r_state == IDLE;
        assign w_out_ready = o_tready[g] | ~r_out_valid;
        // Mode is sampled live on a first beat, then held for the rest of the packet
        assign w_mode      = w_first ? r_mode : r_pkt_mode;
`ifdef AXIS_PKT_MARKER_TAG_EN
        localparam int TW = (CNT_WIDTH < WIDTH - 8) ? CNT_WIDTH : WIDTH - 8;
        assign w_marker = {8'(g), (WIDTH-8)'(r_cnt[TW-1:0])};
`else
        assign w_marker = WIDTH'(r_cnt);
`endif
        always_comb begin
            w_mark  = (w_mode == 2'd3) ? w_first : (w_mode != 2'd0) && i_tlast[g];
            w_data  = w_mark ? w_marker : (w_mode == 2'd2) ? r_fill : i_tdata[WIDTH*g +: WIDTH];
            w_state = w_in ? (i_tlast[g] ? IDLE : IN_PKT) : r_state;
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_state <= IDLE;
            else r_state <= w_state;
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mode       <= 2'd0;
                r_pkt_mode   <= 2'd0;
                r_fill       <= WIDTH'(FILL_DEFAULT);
                r_cnt        <= '0;
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_out_data   <= '0;
                r_skid_valid <= 1'b0;
                r_skid_last  <= 1'b0;
                r_skid_data  <= '0;
            end else begin
                if (w_stb && w_addr == SR_BASE) r_mode <= w_sdata[1:0];
                if (w_stb && w_addr == SR_BASE + 8'd1) r_fill <= WIDTH'(w_sdata);
                if (w_stb && w_addr == SR_BASE + 8'd2) r_cnt <= CNT_WIDTH'(w_sdata);
                else if (w_in && i_tlast[g]) r_cnt <= r_cnt + CNT_WIDTH'(1);
                if (w_in && w_first) r_pkt_mode <= r_mode;
                // Skid holds the beat accepted while the output register was stalled
                if (w_out_ready) begin
                    r_out_valid  <= r_skid_valid | w_in;
                    r_out_data   <= r_skid_valid ? r_skid_data : w_data;
                    r_out_last   <= r_skid_valid ? r_skid_last : i_tlast[g];
                    r_skid_valid <= 1'b0;
                end else if (w_in) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_data;
                    r_skid_last  <= i_tlast[g];
                end
            end
        end
        assign i_tready[g]                     = ~r_skid_valid;
        assign o_tvalid[g]                     = r_out_valid;
        assign o_tlast[g]                      = r_out_last;
        assign o_tdata[WIDTH*g +: WIDTH]       = r_out_data;
        assign pkt_count[CNT_WIDTH*g +: CNT_WIDTH] = r_cnt;
    end
endmodule

// File: tb/tb_axis_pkt_marker.sv
// tb_axis_pkt_marker: directed bench for axis_pkt_marker with one 32-bit channel.
module tb_axis_pkt_marker;
    localparam logic [7:0] SR = 8'd160;
    logic        clk = 1'b0, reset = 1'b1;
    logic [0:0]  set_stb = '0, i_tlast = '0, i_tvalid = '0, i_tready, o_tlast, o_tvalid, o_tready = '1;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0, i_tdata = '0, o_tdata, pkt_count;
    int tests = 0, fails = 0;

    axis_pkt_marker dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        i_tvalid = 1'b0;
        set_stb = 1'b1; set_addr = a; set_data = d;
        step();
        set_stb = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic l, input logic [31:0] e);
        i_tvalid = 1'b1; i_tdata = d; i_tlast = l;
        step();
        check({tag, ".valid"}, 32'(o_tvalid), 32'd1);
        check({tag, ".data"}, o_tdata, e);
        check({tag, ".last"}, 32'(o_tlast), 32'(l));
    endtask

    initial begin
        step(); step();
        check("rst.valid", 32'(o_tvalid), 32'd0);
        check("rst.last", 32'(o_tlast), 32'd0);
        check("rst.data", o_tdata, 32'd0);
        check("rst.count", pkt_count, 32'd0);
        reset = 1'b0;
        step();
        check("rst.ready", 32'(i_tready), 32'd1);
        // MARK_LAST: three 4-beat packets
        wr(SR, 32'd1);
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++)
                beat("m1", 32'h11 * (b + 1), b == 3, (b == 3) ? 32'(p) : 32'h11 * (b + 1));
        check("m1.count", pkt_count, 32'd3);
        // FILL: two 3-beat packets
        wr(SR + 8'd2, 32'd0);
        wr(SR + 8'd1, 32'h12345678);
        wr(SR, 32'd2);
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 3; b++)
                beat("m2", 32'hDEAD0000 + 32'(b), b == 2, (b == 2) ? 32'(p) : 32'h12345678);
        check("m2.count", pkt_count, 32'd2);
        // MARK_FIRST: single-beat packets back to back
        wr(SR + 8'd2, 32'd0);
        wr(SR, 32'd3);
        for (int p = 0; p < 5; p++) begin
            beat("m3", 32'h77, 1'b1, 32'(p));
            check("m3.ready", 32'(i_tready), 32'd1);
        end
        check("m3.count", pkt_count, 32'd5);
        // PASS with output stall: skid fills, ready drops, data held
        wr(SR, 32'd0);
        o_tready = 1'b0;
        i_tvalid = 1'b1; i_tdata = 32'h5A5A0001; i_tlast = 1'b0;
        step();
        check("stall.v1", 32'(o_tvalid), 32'd1);
        check("stall.d1", o_tdata, 32'h5A5A0001);
        check("stall.r1", 32'(i_tready), 32'd1);
        i_tdata = 32'h5A5A0002;
        step();
        check("stall.d2", o_tdata, 32'h5A5A0001);
        check("stall.r2", 32'(i_tready), 32'd0);
        i_tdata = 32'h5A5A0003; i_tlast = 1'b1;
        step();
        check("stall.d3", o_tdata, 32'h5A5A0001);
        check("stall.r3", 32'(i_tready), 32'd0);
        o_tready = 1'b1;
        step();
        check("stall.d4", o_tdata, 32'h5A5A0002);
        check("stall.r4", 32'(i_tready), 32'd1);
        step();
        check("stall.d5", o_tdata, 32'h5A5A0003);
        check("stall.l5", 32'(o_tlast), 32'd1);
        check("stall.count", pkt_count, 32'd6);
        i_tvalid = 1'b0;
        step();
        check("stall.idle", 32'(o_tvalid), 32'd0);
        // Preload and wrap
        wr(SR, 32'd1);
        wr(SR + 8'd2, 32'hFFFFFFFE);
        beat("wrap0", 32'h1, 1'b1, 32'hFFFFFFFE);
        beat("wrap1", 32'h2, 1'b1, 32'hFFFFFFFF);
        beat("wrap2", 32'h3, 1'b1, 32'h0);
        check("wrap.count", pkt_count, 32'd1);
        // Preload coincident with tlast: preload wins
        set_stb = 1'b1; set_addr = SR + 8'd2; set_data = 32'h100;
        beat("pre", 32'hE0, 1'b1, 32'd1);
        set_stb = 1'b0;
        check("pre.count", pkt_count, 32'h100);
        // Mode write mid-packet takes effect on the next packet
        wr(SR, 32'd0);
        beat("mid.a1", 32'hA1, 1'b0, 32'hA1);
        set_stb = 1'b1; set_addr = SR; set_data = 32'd1;
        beat("mid.a2", 32'hA2, 1'b0, 32'hA2);
        set_stb = 1'b0;
        beat("mid.a3", 32'hA3, 1'b1, 32'hA3);
        beat("mid.b1", 32'hB1, 1'b0, 32'hB1);
        beat("mid.b2", 32'hB2, 1'b1, 32'h101);
        check("mid.count", pkt_count, 32'h102);
        // Writes to other addresses are ignored
        wr(SR + 8'd3, 32'd0);
        wr(8'd0, 32'd0);
        beat("ign", 32'hF0, 1'b1, 32'h102);
        // Asynchronous reset mid-packet
        beat("rst.pre", 32'hC1, 1'b0, 32'hC1);
        #2 reset = 1'b1;
        #1;
        check("arst.valid", 32'(o_tvalid), 32'd0);
        check("arst.count", pkt_count, 32'd0);
        check("arst.data", o_tdata, 32'd0);
        i_tvalid = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("arst.ready", 32'(i_tready), 32'd1);
        beat("rst.post", 32'hD1, 1'b1, 32'hD1);
        check("rst.post.count", pkt_count, 32'd1);
        i_tvalid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_pkt_marker.md
Name: axis_pkt_marker

Overview:
Per-channel AXI-stream packet marker for RX data paths, sitting between the radio datapath RX output and the axi_wrapper s_axis_data input. Each channel counts completed packets and, by mode, stamps the packet count into the stream for ILA and host-side loss and ordering checks. Channel count, data width and counter width are parameters, and mode and fill are runtime-selectable over a per-channel settings bus. Each channel has one registered pipeline stage with a skid buffer, so there are no throughput bubbles.

Parameters:
NUM_CHANNELS, 1, number of independent stream channels
WIDTH, 32, tdata width per channel (16..64)
CNT_WIDTH, 32, packet counter width (1..WIDTH); marker = counter zero-extended to WIDTH
SR_BASE, 8'd160, settings base address; regs at SR_BASE+0 (mode), +1 (fill), +2 (counter preload)
FILL_DEFAULT, 32'hABCDBEEF, reset fill pattern; truncated or zero-extended to WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
set_stb  in  NUM_CHANNELS  per-channel settings strobe
set_addr  in  8*NUM_CHANNELS  per-channel settings address
set_data  in  32*NUM_CHANNELS  per-channel settings data
i_tdata  in  WIDTH*NUM_CHANNELS  input data
i_tlast  in  NUM_CHANNELS  input end of packet
i_tvalid  in  NUM_CHANNELS  input valid
i_tready  out  NUM_CHANNELS  input ready
o_tdata  out  WIDTH*NUM_CHANNELS  output data
o_tlast  out  NUM_CHANNELS  output end of packet
o_tvalid  out  NUM_CHANNELS  output valid
o_tready  in  NUM_CHANNELS  output ready
pkt_count  out  CNT_WIDTH*NUM_CHANNELS  live packet counter per channel

Behaviour:
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, pkt_count=0, mode=0, fill=FILL_DEFAULT, skid empty, i_tready=1 once reset deasserts.
- Beat handshake: a beat transfers when tvalid&tready. Input and output are independent AXI handshakes; tdata and tlast stay stable while o_tvalid&!o_tready.
- Latency: 1 cycle input to output.
- Skid buffer: 2-entry, sustains 1 beat/clk. i_tready is registered and equals "skid not holding a beat".
- Mode reg, SR_BASE+0 data[1:0]:
  - 0 PASS: data unchanged.
  - 1 MARK_LAST: last beat data = marker.
  - 2 FILL: non-last beats = fill, last beat = marker.
  - 3 MARK_FIRST: first beat data = marker.
- Mode latching: mode is captured at the first beat of each packet and held until that packet's tlast beat. A mid-packet write takes effect from the next packet.
- Marker value: the count of packets completed before the current one. The first packet after reset carries 0.
- Packet state machine per channel:
  - States: IDLE (expecting first beat) and IN_PKT.
  - IDLE -> IN_PKT on a non-last beat.
  - IN_PKT -> IDLE on a last beat.
  - IDLE -> IDLE on a single-beat packet, which counts as both first and last.
- Counter: increments by 1 on each input tlast beat and wraps modulo 2^CNT_WIDTH. pkt_count is its live value. Counting happens in all modes, including PASS.
- Preload: a write to SR_BASE+2 sets counter = data[CNT_WIDTH-1:0].
  - Preload in the same cycle as a tlast beat: preload wins and the increment is lost.
  - A packet already in flight uses the marker latched at its first beat (MARK_FIRST) or the counter value at its tlast beat (other modes).
- Fill: a write to SR_BASE+1 sets fill = data. It applies immediately, including mid-packet.
- Settings writes to other addresses are ignored.
- Channels are fully independent; there is no cross-channel stall.
- Reset mid-packet: all state clears immediately and asynchronously; the output drops valid. Any partial packet is discarded and upstream must restart at a packet boundary.

Optional Feature:
- Macro: AXIS_PKT_MARKER_TAG_EN.
- When defined, the marker is {channel index in the top 8 bits, counter in the low bits}. This requires WIDTH >= CNT_WIDTH+8; otherwise the counter is truncated to WIDTH-8 bits, while pkt_count stays full width.
- When undefined, the marker is the zero-extended counter only.

Test Plan:
- Mode 1, three 4-beat packets, data 0x11..: last beats carry 0,1,2; other beats unchanged; pkt_count=3.
- Mode 2, fill 0x12345678, 2 packets of 3 beats: output 12345678,12345678,0 then 12345678,12345678,1.
- Mode 3 with single-beat packets back to back at full rate, o_tready=1: one beat/clk out, data 0,1,2,...; no i_tready drop.
- Random o_tready (50%) over 1000 packets, mode 1: no lost or duplicated beats, data stable while stalled, markers contiguous.
- Preload 0xFFFFFFFE; 3 packets: markers FFFFFFFE, FFFFFFFF, 0 (wrap). Preload coincident with tlast: counter = preload value.
- Mode write 0->1 mid-packet: current packet passes unmarked, next packet marked. Async reset mid-packet: o_tvalid=0 the same cycle, pkt_count=0.
